// File: rtl/iob_eth_rx.sv
// MII receive path: preamble/SFD detection, nibble-to-byte assembly, buffer write
// strobes, CRC-32 residue check and a host handshake for each completed frame.
module iob_eth_rx #(
   parameter int MAX_FRAME = 1522
) (
   input  logic        RX_CLK,
   input  logic        rst,
   input  logic        RX_DV,
   input  logic        RX_ER,
   input  logic [3:0]  RX_DATA,
   input  logic        rcv_ack,
   output logic [10:0] addr,
   output logic [7:0]  data,
   output logic        wr,
   output logic        received,
   output logic [10:0] nbytes,
   output logic        crc_err
);

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] MAX_BYTES   = 11'(MAX_FRAME);
   localparam logic [10:0] MIN_BYTES   = 11'd64;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DONE,
      DROP
   } state_t;

   state_t      state, state_n;
   logic [3:0]  nib_lo;
   logic        nib_odd;
   logic [10:0] byte_cnt;
   logic [31:0] crc;
   logic        ack_armed;
   logic [7:0]  rx_byte;

   logic        start_frame;
   logic        store_lo;
   logic        write_byte;
   logic        report;
   logic        ack_take;

   assign rx_byte = {RX_DATA, nib_lo};

   function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      c = c_in ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      return c;
   endfunction

   always_ff @(posedge RX_CLK) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      start_frame = 1'b0;
      store_lo    = 1'b0;
      write_byte  = 1'b0;
      report      = 1'b0;
      ack_take    = 1'b0;
      case (state)
         IDLE: begin
            if (RX_DV) state_n = (RX_DATA == 4'h5) ? PREAMBLE : DROP;
         end
         PREAMBLE: begin
            if (!RX_DV)                state_n = IDLE;
            else if (RX_ER)            state_n = DROP;
            else if (RX_DATA == 4'h5)  state_n = PREAMBLE;
            else if (RX_DATA == 4'hD) begin
               state_n     = DATA;
               start_frame = 1'b1;
            end
            else                       state_n = DROP;
         end
         DATA: begin
            // A dangling low nibble at frame end is simply never paired.
            if (!RX_DV) begin
               if (byte_cnt < MIN_BYTES) state_n = IDLE;
               else begin
                  state_n = DONE;
                  report  = 1'b1;
               end
            end
            else if (RX_ER)                 state_n = DROP;
            else if (!nib_odd)              store_lo = 1'b1;
            else if (byte_cnt >= MAX_BYTES) state_n = DROP;
            else                            write_byte = 1'b1;
         end
         DONE: begin
            if (rcv_ack && ack_armed) begin
               state_n  = DROP;
               ack_take = 1'b1;
            end
         end
         DROP: begin
            if (!RX_DV) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         addr      <= '0;
         data      <= '0;
         wr        <= 1'b0;
         received  <= 1'b0;
         nbytes    <= '0;
         crc_err   <= 1'b0;
         crc       <= 32'hFFFFFFFF;
         nib_lo    <= '0;
         nib_odd   <= 1'b0;
         byte_cnt  <= '0;
         ack_armed <= 1'b0;
      end
      else begin
         wr <= write_byte;
         if (start_frame) begin
            crc      <= 32'hFFFFFFFF;
            byte_cnt <= '0;
            nib_odd  <= 1'b0;
         end
         if (store_lo) begin
            nib_lo  <= RX_DATA;
            nib_odd <= 1'b1;
         end
         if (write_byte) begin
            data     <= rx_byte;
            addr     <= byte_cnt;
            byte_cnt <= byte_cnt + 11'd1;
            crc      <= crc_byte(crc, rx_byte);
            nib_odd  <= 1'b0;
         end
         // A held-high ack must be seen low once before it can release this frame.
         if (report) begin
            received  <= 1'b1;
            nbytes    <= byte_cnt;
            crc_err   <= (crc != CRC_RESIDUE);
            ack_armed <= 1'b0;
         end
         else if (state == DONE && !rcv_ack) begin
            ack_armed <= 1'b1;
         end
         if (ack_take) received <= 1'b0;
      end
   end

endmodule
